addr_bus_driver: RTL
====================

ADDR_BUS_DRIVER -- requirements
Module: addr_bus_driver

Interface
REQ-001 SHALL have parameter ADDR_BUS_WIDTH, default 8, address bus width in bits.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, range 1-15, cycles the address is driven before it is declared valid.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1, range 1-15, cycles addr_valid stays high.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 req  input  5  per-source address request; bit0 M, bit1 XY, bit2 J, bit3 PC, bit4 INC.
REQ-008 addr_m, addr_xy, addr_j, addr_pc, addr_inc  input  ADDR_BUS_WIDTH each  source register values.
REQ-009 address  output  ADDR_BUS_WIDTH  value driven onto the shared address bus.
REQ-010 addr_oe  output  1  bus drive enable; address is meaningful only while high.
REQ-011 addr_valid  output  1  address settled; memory and INC16 sample while high.
REQ-012 grant  output  5  one-hot owner of the bus, same bit order as req.
REQ-013 ack  output  1  one-cycle pulse: granted transaction completed.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, VALID, RELEASE.
REQ-016 IDLE: if req!=0, next cycle SHALL enter SETTLE with grant one-hot to the winner, address = winner's source value captured that edge, addr_oe=1.
REQ-017 Fixed priority (macro absent): PC > M > XY > J > INC.
REQ-018 Captured address SHALL stay constant for the whole transaction regardless of source input changes.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles with addr_valid=0, then enter VALID.
REQ-020 VALID SHALL last exactly HOLD_CYCLES cycles with addr_valid=1; ack SHALL pulse on the last VALID cycle only.
REQ-021 RELEASE SHALL last one cycle: addr_oe=0, addr_valid=0, grant=0, address=0; then IDLE.
REQ-022 Requester SHALL hold its req bit until ack; if granted bit drops during SETTLE or VALID, next cycle SHALL be RELEASE with no ack (abort).
REQ-023 Other req bits changing mid-transaction SHALL have no effect; they are re-arbitrated in IDLE only.
REQ-024 Minimum spacing: a source requesting back-to-back SHALL see one IDLE cycle between RELEASE and next grant.
REQ-025 In IDLE: address=0, addr_oe=0, addr_valid=0, grant=0, ack=0.
REQ-026 Counter SHALL be 4 bits; no wrap occurs within legal parameter range.

Reset
REQ-027 rst high SHALL immediately force IDLE and all outputs to 0, including mid-transaction; no ack issued.
REQ-028 First arbitration SHALL occur on the first rising edge after rst deasserts with req!=0.
REQ-029 Round-robin pointer (when compiled in) SHALL reset to point at bit0 (M) highest.

Configuration
REQ-030 Macro ADDR_BUS_ROUND_ROBIN_EN: when defined, arbitration SHALL be round-robin; highest priority is the bit after the last granted source (wrapping INC->M), pointer updated only on ack (not abort).
REQ-031 When ADDR_BUS_ROUND_ROBIN_EN is undefined, fixed priority per REQ-017 SHALL apply and no pointer register SHALL exist.

Verification
REQ-032 Defaults, req=5'b01000, addr_pc=8'h3C held -> grant=01000, address=8'h3C from cycle 1, addr_valid in cycle 3, ack in cycle 3, addr_oe low cycle 4, IDLE cycle 5.
REQ-033 Fixed priority, req=5'b11111 -> grant=01000 (PC); drop PC after ack -> next grant 00001 (M).
REQ-034 Round-robin build, req=5'b11111 held -> grants M, XY, J, PC, INC, M in sequence.
REQ-035 req=5'b00010, addr_xy=8'hA5; deassert req in cycle 2 -> RELEASE cycle 3, ack never pulses.
REQ-036 addr_j changes 8'h11->8'h22 during SETTLE -> address remains 8'h11 until RELEASE.
REQ-037 rst asserted asynchronously during VALID -> all outputs 0 before next clock edge; no ack.

Source files
------------

// File: rtl/addr_bus_driver.sv
// -----------------------------------------------------------------------------
// addr_bus_driver
// Arbitrates five address sources (M, XY, J, PC, INC) onto one shared address
// bus. Each transaction runs SETTLE -> VALID -> RELEASE. The winner's address
// is captured at grant time and held until the transaction ends.
//
// Optional build macro: ADDR_BUS_ROUND_ROBIN_EN
//   undefined : fixed priority PC > M > XY > J > INC, no pointer register
//   defined   : round-robin, pointer advances past the owner only on ack
// -----------------------------------------------------------------------------
module addr_bus_driver #(
  parameter int ADDR_BUS_WIDTH = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                req,
  input  logic [ADDR_BUS_WIDTH-1:0] addr_m,
  input  logic [ADDR_BUS_WIDTH-1:0] addr_xy,
  input  logic [ADDR_BUS_WIDTH-1:0] addr_j,
  input  logic [ADDR_BUS_WIDTH-1:0] addr_pc,
  input  logic [ADDR_BUS_WIDTH-1:0] addr_inc,
  output logic [ADDR_BUS_WIDTH-1:0] address,
  output logic                      addr_oe,
  output logic                      addr_valid,
  output logic [4:0]                grant,
  output logic                      ack,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_VALID   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_nxt_state;
  logic [3:0]                r_cnt;
  logic [3:0]                w_nxt_cnt;
  logic                      w_nxt_ack;
  logic [4:0]                w_grant_sel;
  logic [ADDR_BUS_WIDTH-1:0] w_mux_addr;
  logic                      w_owner_req;

  logic [ADDR_BUS_WIDTH-1:0] r_address;
  logic                      r_addr_oe;
  logic                      r_addr_valid;
  logic [4:0]                r_grant;
  logic                      r_ack;
  logic                      r_busy;

`ifdef ADDR_BUS_ROUND_ROBIN_EN
  logic [2:0] r_rr_ptr;
  logic [2:0] w_ptr_after;

  // Round-robin pick: scan from the pointer upward, wrapping INC -> M
  function automatic logic [4:0] arb_rr(input logic [4:0] r, input logic [2:0] ptr);
    logic [4:0] g;
    logic       found;
    logic [3:0] idx;
    g     = 5'b00000;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx > 4'd4) begin
        idx = idx - 4'd5;
      end else begin
        idx = idx;
      end
      if (!found && r[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
    return g;
  endfunction

  // Pointer value that makes the source after the current owner highest
  always_comb begin
    w_ptr_after = r_rr_ptr;
    case (r_grant)
      5'b00001: w_ptr_after = 3'd1;
      5'b00010: w_ptr_after = 3'd2;
      5'b00100: w_ptr_after = 3'd3;
      5'b01000: w_ptr_after = 3'd4;
      5'b10000: w_ptr_after = 3'd0;
      default:  w_ptr_after = r_rr_ptr;
    endcase
  end

  // Pointer advances only on a completed transaction, never on abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 3'd0;
    end else if (r_ack) begin
      r_rr_ptr <= w_ptr_after;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign w_grant_sel = arb_rr(req, r_rr_ptr);
`else
  // Fixed priority pick: PC > M > XY > J > INC
  function automatic logic [4:0] arb_fixed(input logic [4:0] r);
    logic [4:0] g;
    g = 5'b00000;
    if (r[3]) begin
      g = 5'b01000;
    end else if (r[0]) begin
      g = 5'b00001;
    end else if (r[1]) begin
      g = 5'b00010;
    end else if (r[2]) begin
      g = 5'b00100;
    end else if (r[4]) begin
      g = 5'b10000;
    end else begin
      g = 5'b00000;
    end
    return g;
  endfunction

  assign w_grant_sel = arb_fixed(req);
`endif

  // One-hot address mux for the arbitration winner
  always_comb begin
    w_mux_addr = ({ADDR_BUS_WIDTH{w_grant_sel[0]}} & addr_m)
               | ({ADDR_BUS_WIDTH{w_grant_sel[1]}} & addr_xy)
               | ({ADDR_BUS_WIDTH{w_grant_sel[2]}} & addr_j)
               | ({ADDR_BUS_WIDTH{w_grant_sel[3]}} & addr_pc)
               | ({ADDR_BUS_WIDTH{w_grant_sel[4]}} & addr_inc);
  end

  // The current owner still requesting; losing it aborts the transaction
  assign w_owner_req = ((req & r_grant) != 5'b00000);

  // Next-state, cycle counter and ack decision
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = 4'd0;
        if (req != 5'b00000) begin
          w_nxt_state = S_SETTLE;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!w_owner_req) begin
          w_nxt_state = S_RELEASE;
          w_nxt_cnt   = 4'd0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_nxt_state = S_VALID;
          w_nxt_cnt   = 4'd0;
          w_nxt_ack   = (HOLD_LAST == 4'd0);
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      S_VALID: begin
        if (!w_owner_req || (r_cnt == HOLD_LAST)) begin
          w_nxt_state = S_RELEASE;
          w_nxt_cnt   = 4'd0;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
          w_nxt_ack = ((r_cnt + 4'd1) == HOLD_LAST);
        end
      end
      S_RELEASE: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = 4'd0;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = 4'd0;
      end
    endcase
  end

  // State, counter and registered bus outputs derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_address    <= {ADDR_BUS_WIDTH{1'b0}};
      r_addr_oe    <= 1'b0;
      r_addr_valid <= 1'b0;
      r_grant      <= 5'b00000;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_ack   <= w_nxt_ack;
      r_busy  <= (w_nxt_state != S_IDLE);
      case (w_nxt_state)
        S_SETTLE: begin
          r_addr_oe    <= 1'b1;
          r_addr_valid <= 1'b0;
          if (r_state == S_IDLE) begin
            r_address <= w_mux_addr;
            r_grant   <= w_grant_sel;
          end else begin
            r_address <= r_address;
            r_grant   <= r_grant;
          end
        end
        S_VALID: begin
          r_addr_oe    <= 1'b1;
          r_addr_valid <= 1'b1;
          r_address    <= r_address;
          r_grant      <= r_grant;
        end
        default: begin
          r_addr_oe    <= 1'b0;
          r_addr_valid <= 1'b0;
          r_address    <= {ADDR_BUS_WIDTH{1'b0}};
          r_grant      <= 5'b00000;
        end
      endcase
    end
  end

  assign address    = r_address;
  assign addr_oe    = r_addr_oe;
  assign addr_valid = r_addr_valid;
  assign grant      = r_grant;
  assign ack        = r_ack;
  assign busy       = r_busy;

endmodule
